// File: rtl/serial_adder_bus_ctrl.sv
// serial_adder_bus_ctrl
//   Bus-side front end for the 8-bit serial adder. Operand pairs written by
//   the processor are queued in a command FIFO. Each pair is issued to the
//   adder with a one-cycle start pulse. The sum is captured on the rising
//   edge of done and queued in a result FIFO that the processor reads.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_en/wr_data       push operand pair ([7:0]=a, [15:8]=b); wr_ready = not full
//   rd_en/rd_data       pop result; rd_data shows the FIFO head; rd_valid = not empty
//   add_a/add_b         operands to the adder, held for the whole operation
//   add_start           one-cycle start pulse to the adder
//   add_c/add_done      sum and done from the adder
//   busy                operation in flight or commands pending
//   cmd_count/res_count FIFO occupancies
//   err_timeout/clr_err sticky timeout flag and its clear
//
// state  | meaning
// S_IDLE | waiting for a command and free result space
// S_ISSUE| add_start high, timeout counter cleared
// S_WAIT | waiting for done rising edge or timeout
// S_DRAIN| waiting for add_done low before the next command
module serial_adder_bus_ctrl #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [15:0]                  wr_data,
  output logic                         wr_ready,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  output logic [7:0]                   add_a,
  output logic [7:0]                   add_b,
  output logic                         add_start,
  input  logic [7:0]                   add_c,
  input  logic                         add_done,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic [$clog2(RES_DEPTH):0]   res_count,
  output logic                         err_timeout,
  input  logic                         clr_err
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RES_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CPW:0]  CMD_FULL  = (CPW + 1)'(CMD_DEPTH);
  localparam logic [RPW:0]  RES_FULL  = (RPW + 1)'(RES_DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CPW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CPW:0]   cmd_count_q, cmd_count_d;
  logic [RPW-1:0] res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
  logic [RPW:0]   res_count_q, res_count_d;
  logic [7:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic           add_start_q, add_start_d;
  logic           add_done_q, add_done_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;

  logic [15:0]    cmd_mem [CMD_DEPTH];
  logic [7:0]     res_mem [RES_DEPTH];

  logic cmd_push, cmd_pop, res_push, res_pop, done_rise, err_set;

  assign done_rise = add_done & ~add_done_q;

  always_comb begin
    state_d      = state_q;
    cmd_wr_ptr_d = cmd_wr_ptr_q;
    cmd_rd_ptr_d = cmd_rd_ptr_q;
    cmd_count_d  = cmd_count_q;
    res_wr_ptr_d = res_wr_ptr_q;
    res_rd_ptr_d = res_rd_ptr_q;
    res_count_d  = res_count_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_start_d  = 1'b0;
    add_done_d   = add_done;
    timer_d      = timer_q;
    cmd_push     = wr_en & (cmd_count_q != CMD_FULL);
    cmd_pop      = 1'b0;
    res_push     = 1'b0;
    res_pop      = rd_en & (res_count_q != '0);
    err_set      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Issue only with a free result slot so the sum can always be stored.
        if ((cmd_count_q != '0) && (res_count_q < RES_FULL)) begin
          cmd_pop     = 1'b1;
          add_a_d     = cmd_mem[cmd_rd_ptr_q][7:0];
          add_b_d     = cmd_mem[cmd_rd_ptr_q][15:8];
          add_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          res_push = 1'b1;
          state_d  = S_DRAIN;
        end else if (timer_q == TIMER_MAX) begin
          err_set = 1'b1;
          state_d = S_DRAIN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!add_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_push) cmd_wr_ptr_d = cmd_wr_ptr_q + 1'b1;
    if (cmd_pop)  cmd_rd_ptr_d = cmd_rd_ptr_q + 1'b1;
    if (cmd_push && !cmd_pop)      cmd_count_d = cmd_count_q + 1'b1;
    else if (!cmd_push && cmd_pop) cmd_count_d = cmd_count_q - 1'b1;

    if (res_push) res_wr_ptr_d = res_wr_ptr_q + 1'b1;
    if (res_pop)  res_rd_ptr_d = res_rd_ptr_q + 1'b1;
    if (res_push && !res_pop)      res_count_d = res_count_q + 1'b1;
    else if (!res_push && res_pop) res_count_d = res_count_q - 1'b1;

    // A new timeout wins over a coincident clear.
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_count_q  <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_count_q  <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_start_q  <= 1'b0;
      add_done_q   <= 1'b0;
      timer_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_wr_ptr_q <= cmd_wr_ptr_d;
      cmd_rd_ptr_q <= cmd_rd_ptr_d;
      cmd_count_q  <= cmd_count_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      res_count_q  <= res_count_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_start_q  <= add_start_d;
      add_done_q   <= add_done_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

  // Storage only; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= wr_data;
    if (res_push) res_mem[res_wr_ptr_q] <= add_c;
  end

  assign wr_ready    = (cmd_count_q != CMD_FULL);
  assign rd_valid    = (res_count_q != '0);
  assign rd_data     = rd_valid ? res_mem[res_rd_ptr_q] : 8'h00;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_start   = add_start_q;
  assign busy        = (state_q != S_IDLE) | (cmd_count_q != '0);
  assign cmd_count   = cmd_count_q;
  assign res_count   = res_count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_serial_adder_bus_ctrl.sv
module tb_serial_adder_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  add_a, add_b;
  logic        add_start;
  logic [7:0]  add_c;
  logic        add_done;
  logic        busy;
  logic [2:0]  cmd_count;
  logic [2:0]  res_count;
  logic        err_timeout;
  logic        clr_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // adder model control
  logic       model_en = 1'b1;
  logic       man_done = 1'b0;
  int         lat      = 1;
  int         done_len = 2;
  int         start_cnt = 0;

  serial_adder_bus_ctrl #(.CMD_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_c(add_c), .add_done(add_done),
    .busy(busy), .cmd_count(cmd_count), .res_count(res_count),
    .err_timeout(err_timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Serial adder stand-in: done rises lat cycles after the start pulse and
  // stays high done_len cycles. With model_en low, done follows man_done.
  initial begin : adder_model
    int ph, cnt;
    logic [7:0] op_a, op_b;
    ph = 0; cnt = 0; op_a = '0; op_b = '0;
    add_done = 1'b0;
    add_c = 8'h00;
    forever begin
      @(negedge clk);
      if (add_start) start_cnt++;
      if (!model_en) begin
        add_done = man_done;
        ph = 0;
      end else if (ph == 0) begin
        add_done = 1'b0;
        if (add_start) begin
          op_a = add_a; op_b = add_b; cnt = lat; ph = 1;
        end
      end else if (ph == 1) begin
        cnt--;
        if (cnt == 0) begin
          add_c = op_a + op_b; add_done = 1'b1; cnt = done_len; ph = 2;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          add_done = 1'b0; ph = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no_finish, need finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_wait(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!rd_valid && n < 100) begin tick(); n++; end
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!add_start && n < 100) begin tick(); n++; end
    check({tag, "_start"}, add_start, 1);
  endtask

  logic [15:0] pw_cmd [10] = '{16'h0101, 16'h03FE, 16'hAA55, 16'h8180, 16'h3412,
                               16'hFFFF, 16'h0000, 16'h9D64, 16'h053C, 16'hA0A0};
  logic [7:0]  pw_sum [10] = '{8'h02, 8'h01, 8'hFF, 8'h01, 8'h46,
                               8'hFE, 8'h00, 8'h01, 8'h41, 8'h40};
  logic [7:0]  bp_sum [8]  = '{8'h03, 8'h30, 8'h10, 8'h80, 8'h22, 8'hFF, 8'h2C, 8'h12};

  initial begin : main
    int s0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_a", add_a, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_res_count", res_count, 0);
    check("rst_err", err_timeout, 0);

    // single op, done held 2 cycles
    lat = 3; done_len = 2;
    s0 = start_cnt;
    push_cmd(16'h053C);
    check("s1_start_early", add_start, 0);
    check("s1_cmd_count", cmd_count, 1);
    check("s1_busy", busy, 1);
    tick();
    check("s1_start", add_start, 1);
    check("s1_a", add_a, 8'h3C);
    check("s1_b", add_b, 8'h05);
    tick(); tick();
    check("s1_start_off", add_start, 0);
    check("s1_a_hold", add_a, 8'h3C);
    check("s1_b_hold", add_b, 8'h05);
    check("s1_no_early_result", rd_valid, 0);
    wait_idle("s1");
    check("s1_start_pulses", start_cnt - s0, 1);
    check("s1_res_count", res_count, 1);
    pop_wait(8'h41, "s1_pop");
    check("s1_empty", rd_valid, 0);

    // modulo-256 wrap
    lat = 1;
    push_cmd(16'h01FF);
    push_cmd(16'h8080);
    wait_idle("wr");
    check("wr_res_count", res_count, 2);
    pop_wait(8'h00, "wr_pop0");
    pop_wait(8'h00, "wr_pop1");

    // backpressure
    push_cmd(16'h0201); push_cmd(16'h2010); push_cmd(16'h20F0); push_cmd(16'h017F);
    wait_idle("bp_fill");
    check("bp_res_full", res_count, 4);
    s0 = start_cnt;
    push_cmd(16'h1111); push_cmd(16'h55AA);
    repeat (10) tick();
    check("bp_no_start", start_cnt - s0, 0);
    check("bp_cmd2", cmd_count, 2);
    check("bp_busy", busy, 1);
    push_cmd(16'h64C8); push_cmd(16'h0909);
    check("bp_cmd4", cmd_count, 4);
    check("bp_wr_ready", wr_ready, 0);
    push_cmd(16'hEEEE);
    check("bp_drop_count", cmd_count, 4);
    for (int i = 0; i < 8; i++) pop_wait(bp_sum[i], $sformatf("bp_pop%0d", i));
    wait_idle("bp_end");
    check("bp_final_empty", rd_valid, 0);
    check("bp_final_cmd", cmd_count, 0);
    check("bp_starts", start_cnt - s0, 4);

    // pointer wrap, interleaved reads
    s0 = start_cnt;
    lat = 2;
    for (int i = 0; i < 10; i++) begin
      push_cmd(pw_cmd[i]);
      if (i > 0) pop_wait(pw_sum[i-1], $sformatf("pw_pop%0d", i-1));
    end
    pop_wait(pw_sum[9], "pw_pop9");
    wait_idle("pw");
    check("pw_starts", start_cnt - s0, 10);
    check("pw_empty", rd_valid, 0);

    // timeout: err after TIMEOUT+1 WAIT cycles
    model_en = 1'b0; man_done = 1'b0;
    push_cmd(16'h0101);
    wait_start("to1");
    repeat (32) tick();
    check("to1_err_before", err_timeout, 0);
    tick();
    check("to1_err_set", err_timeout, 1);
    wait_idle("to1");
    check("to1_no_result", res_count, 0);
    model_en = 1'b1; lat = 1;
    push_cmd(16'h0202);
    pop_wait(8'h04, "to_next");
    check("to_err_sticky", err_timeout, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("to_clr", err_timeout, 0);
    model_en = 1'b0;
    push_cmd(16'h0303);
    wait_start("to2");
    repeat (32) tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("to2_set_wins", err_timeout, 1);
    wait_idle("to2");
    check("to2_no_result", res_count, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // reset mid-WAIT, late done
    push_cmd(16'h0404);
    wait_start("rw");
    repeat (3) tick();
    s0 = start_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    man_done = 1'b1;
    repeat (4) tick();
    check("rw_busy", busy, 0);
    check("rw_rd_valid", rd_valid, 0);
    check("rw_res_count", res_count, 0);
    check("rw_cmd_count", cmd_count, 0);
    check("rw_add_a", add_a, 0);
    check("rw_add_b", add_b, 0);
    check("rw_wr_ready", wr_ready, 1);
    check("rw_err", err_timeout, 0);
    check("rw_no_start", start_cnt - s0, 0);
    man_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
